adder_rr_scheduler: RTL and testbench

Shares one 8-bit adder (sum plus carry) between NUM_REQ requesters using round-robin arbitration and valid/ready handshakes. Each accepted request is captured, added in a registered stage, and returned on a single response channel tagged with the requester ID. Sits between the top-level pin wrapper's operand sources and the output pins.

---
 rtl/adder_sched_pkg.sv | 19 +
 rtl/adder_rr_scheduler_rr_arbiter.sv | 32 +++
 rtl/adder_rr_scheduler.sv | 117 +++++++++++
 tb/tb_adder_rr_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
// Optional build macro: ADDER_SCHED_SAT_EN (saturating sum).
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int DATA_W_DEFAULT = 8;

  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);

  int idx;

  always_comb begin
    any_grant = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (!any_grant && req[idx]) begin
        any_grant = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    grant_oh = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// One shared DATA_W adder, round-robin over NUM_REQ requesters.
// Build macro ADDER_SCHED_SAT_EN: saturate sum to all ones on carry.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEFAULT,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_carry,
  output logic [IW-1:0]             rsp_id,
  output logic                      busy
);

  sched_state_t state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IW-1:0]     id_q, id_d;
  logic [DATA_W:0]   ext;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]      grant_idx;
  logic               any_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx),
    .any_grant  (any_grant)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gid_d     = gid_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    id_d      = id_q;
    req_ready = '0;
    ext       = '0;
    unique case (state_q)
      IDLE: begin
        // ready is withheld while reset is held so the pins read idle
        if (any_grant && !rst) begin
          req_ready = grant_oh;
          if (|(req_valid & grant_oh)) begin
            a_d     = req_a[int'(grant_idx)*DATA_W +: DATA_W];
            b_d     = req_b[int'(grant_idx)*DATA_W +: DATA_W];
            gid_d   = grant_idx;
            last_d  = grant_idx;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        ext     = {1'b0, a_q} + {1'b0, b_q};
        carry_d = ext[DATA_W];
`ifdef ADDER_SCHED_SAT_EN
        sum_d   = ext[DATA_W] ? {DATA_W{1'b1}} : ext[DATA_W-1:0];
`else
        sum_d   = ext[DATA_W-1:0];
`endif
        id_d    = gid_q;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed-vector bench for adder_rr_scheduler (NUM_REQ=2, DATA_W=8).
module tb_adder_rr_scheduler;

`ifdef ADDER_SCHED_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_carry;
  logic [0:0]  rsp_id;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;
  int multi_rdy = 0;

  adder_rr_scheduler #(.NUM_REQ(2), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (req_ready[0] && req_ready[1]) multi_rdy++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xs(input logic [7:0] s, input logic c);
    return (SAT && c) ? 8'hFF : s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // full transaction with rsp_ready=1; leaves req_valid as given
  task automatic do_req(input string tag, input logic [1:0] vld,
                        input logic [15:0] a, input logic [15:0] b,
                        input int eid, input logic [7:0] es,
                        input logic ec);
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b1;
    #1;
    check({tag, ".rdy"}, 32'(req_ready), 32'(2'b01 << eid));
    step();
    check({tag, ".busy"}, 32'(busy), 1);
    check({tag, ".exec_v"}, 32'(rsp_valid), 0);
    check({tag, ".exec_rdy"}, 32'(req_ready), 0);
    step();
    check({tag, ".v"}, 32'(rsp_valid), 1);
    check({tag, ".sum"}, 32'(rsp_sum), 32'(xs(es, ec)));
    check({tag, ".c"}, 32'(rsp_carry), 32'(ec));
    check({tag, ".id"}, 32'(rsp_id), 32'(eid));
    step();
    check({tag, ".done_v"}, 32'(rsp_valid), 0);
    check({tag, ".done_busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst.v", 32'(rsp_valid), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.rdy", 32'(req_ready), 0);
    check("rst.sum", 32'(rsp_sum), 0);
    check("rst.c", 32'(rsp_carry), 0);
    check("rst.id", 32'(rsp_id), 0);
    step();
    rst = 1'b0;
    step();

    // single request on requester 0
    do_req("single", 2'b01, 16'h0012, 16'h0034, 0, 8'h46, 1'b0);
    req_valid = '0;

    // wrap-around on requester 1
    do_req("wrap", 2'b10, 16'hFF00, 16'h0100, 1, 8'h00, 1'b1);
    req_valid = '0;

    // fairness: both continuously valid
    do_req("fair0", 2'b11, 16'h8005, 16'h9006, 0, 8'h0B, 1'b0);
    do_req("fair1", 2'b11, 16'h8005, 16'h9006, 1, 8'h10, 1'b1);
    do_req("fair2", 2'b11, 16'h8005, 16'h9006, 0, 8'h0B, 1'b0);
    do_req("fair3", 2'b11, 16'h8005, 16'h9006, 1, 8'h10, 1'b1);
    req_valid = '0;
    check("fair.onehot", 32'(multi_rdy), 0);

    // backpressure: C8+64 = 12C held for 5 cycles
    req_valid = 2'b01;
    req_a     = 16'h00C8;
    req_b     = 16'h0064;
    rsp_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      req_a = 16'(16'h1111 * (i + 1));
      check("bp.v", 32'(rsp_valid), 1);
      check("bp.sum", 32'(rsp_sum), 32'(xs(8'h2C, 1'b1)));
      check("bp.c", 32'(rsp_carry), 1);
      check("bp.id", 32'(rsp_id), 0);
      check("bp.rdy", 32'(req_ready), 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    check("bp.done_v", 32'(rsp_valid), 0);
    check("bp.done_busy", 32'(busy), 0);

    // withdrawal: req1 pulses during EXEC only
    req_valid = 2'b01;
    req_a     = 16'h0001;
    req_b     = 16'h0002;
    step();
    req_valid = 2'b10;
    #1;
    check("wd.exec_rdy", 32'(req_ready), 0);
    step();
    req_valid = '0;
    check("wd.v", 32'(rsp_valid), 1);
    check("wd.sum", 32'(rsp_sum), 8'h03);
    check("wd.id", 32'(rsp_id), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wd.idle_v", 32'(rsp_valid), 0);
      check("wd.idle_busy", 32'(busy), 0);
      check("wd.idle_rdy", 32'(req_ready), 0);
    end

`ifdef ADDER_SCHED_SAT_EN
    do_req("sat", 2'b10, 16'hF000, 16'h2000, 1, 8'h10, 1'b1);
    req_valid = '0;
`endif

    // reset in the middle of a held response
    req_valid = 2'b11;
    req_a     = 16'h1111;
    req_b     = 16'h2222;
    rsp_ready = 1'b0;
    step();
    step();
    check("mid.v", 32'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    check("mid.rst_v", 32'(rsp_valid), 0);
    check("mid.rst_busy", 32'(busy), 0);
    check("mid.rst_rdy", 32'(req_ready), 0);
    check("mid.rst_sum", 32'(rsp_sum), 0);
    check("mid.rst_id", 32'(rsp_id), 0);
    step();
    rst = 1'b0;
    do_req("post", 2'b11, 16'h0507, 16'h0609, 0, 8'h10, 1'b0);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
